// File: rtl/occ_arb_pkg.sv
// Shared definitions for the Occ port arbiter: width helpers and round-robin pick.
// Latency: none (pure combinational helpers).
// Backpressure: none (no state).
//
// Contents:
//   lane_w(n)   - lane index width, never below 1 so a single lane still has a tag bit
//   cnt_w(m)    - outstanding counter width, wide enough to hold m itself
//   rr_pick()   - first requester at or above ptr, wrapping at n_lanes
package occ_arb_pkg;

  localparam int MAX_LANES = 16;
  localparam int PICK_W    = 4;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } rr_pick_t;

  function automatic int lane_w(input int n_lanes);
    return (n_lanes > 1) ? $clog2(n_lanes) : 1;
  endfunction

  function automatic int cnt_w(input int max_out);
    return $clog2(max_out) + 1;
  endfunction

  // req is zero-extended to MAX_LANES; only the low n_lanes bits take part.
  // ptr must be below n_lanes, so the wrapped candidate never leaves the range.
  function automatic rr_pick_t rr_pick(input logic [MAX_LANES-1:0] req,
                                       input logic [PICK_W-1:0]    ptr,
                                       input int                   n_lanes);
    rr_pick_t   res;
    logic [4:0] cand;
    res = '0;
    for (int off = 0; off < MAX_LANES; off++) begin
      if (off < n_lanes) begin
        cand = {1'b0, ptr} + 5'(off);
        if (cand >= 5'(n_lanes)) begin
          cand = cand - 5'(n_lanes);
        end
        if (!res.found && req[cand[3:0]]) begin
          res.found = 1'b1;
          res.idx   = cand[3:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/occ_tag_fifo.sv
// In-order tag FIFO holding the lane index of every Occ read in flight.
// Latency: push visible at head the cycle after the push edge; head read combinationally.
// Backpressure: push ignored when full unless a pop frees a slot in the same cycle.
//
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset (empties the FIFO)
//   push, push_dat      - enqueue a tag
//   pop, pop_dat        - dequeue; pop_dat is the current head
//   count, full, empty  - occupancy
module occ_tag_fifo
  import occ_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign pop_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

endmodule

// File: rtl/occ_port_arbiter.sv
// Shares one Occ read port among N_LANES lanes; round-robin grant, in-order return steering.
// Latency: grant combinational in t, Occ strobe in t+1; lane strobe 1 cycle after Occ valid.
// Backpressure: no grant while is_start=0 or MAX_OUT reads are outstanding (registered count).
//
// Ports:
//   clk, rst_n                        - clock, synchronous active-low reset
//   is_start                          - run enable; low blocks new grants only
//   lane_ce_i, lane_addr_i            - per-lane read request and address (lane k at [k*ADDR_W +: ADDR_W])
//   lane_gnt_o                        - one-hot grant, same cycle as acceptance
//   lane_valid_o, lane_data_o         - one-hot return strobe and broadcast data
//   ce_rom_Occ_o, addr_rom_Occ_o      - registered Occ read strobe and address
//   data_Occ_i, data_Occ_valid_i      - Occ read data, returned in issue order
//   busy_o, err_o                     - reads in flight, sticky spurious-return error
module occ_port_arbiter
  import occ_arb_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      is_start,
  input  logic [N_LANES-1:0]        lane_ce_i,
  input  logic [N_LANES*ADDR_W-1:0] lane_addr_i,
  output logic [N_LANES-1:0]        lane_gnt_o,
  output logic [N_LANES-1:0]        lane_valid_o,
  output logic [DATA_W-1:0]         lane_data_o,
  output logic                      ce_rom_Occ_o,
  output logic [ADDR_W-1:0]         addr_rom_Occ_o,
  input  logic [DATA_W-1:0]         data_Occ_i,
  input  logic                      data_Occ_valid_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int LANE_W = lane_w(N_LANES);
  localparam int CNT_W  = cnt_w(MAX_OUT);

  logic [LANE_W-1:0]    rr_ptr;
  logic [MAX_LANES-1:0] req_ext;
  rr_pick_t             pick;
  logic                 gnt_vld;
  logic [LANE_W-1:0]    win;
  logic [LANE_W-1:0]    head_tag;
  logic [CNT_W-1:0]     tag_count;
  logic                 tag_full;
  logic                 tag_empty;
  logic                 ret_vld;
  logic                 spur_vld;

  // ---------------------------------------------------------------------------
  // Grant: full is taken from the registered count, so a pop in the same cycle
  // does not open a slot until the next cycle. Grants are suppressed while in
  // reset so a lane never sees an acceptance that the reset then discards.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ext                = '0;
    req_ext[N_LANES-1:0]   = lane_ce_i;
    pick                   = rr_pick(req_ext, PICK_W'(rr_ptr), N_LANES);
    win                    = LANE_W'(pick.idx);
    gnt_vld                = rst_n & is_start & ~tag_full & pick.found;
    lane_gnt_o             = gnt_vld ? (N_LANES'(1) << win) : '0;
  end

  // A return with nothing outstanding has no owner: drop it and flag it.
  assign ret_vld  = data_Occ_valid_i & ~tag_empty;
  assign spur_vld = data_Occ_valid_i &  tag_empty;

  occ_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (LANE_W),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (gnt_vld),
    .push_dat (win),
    .pop      (ret_vld),
    .pop_dat  (head_tag),
    .count    (tag_count),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  // ---------------------------------------------------------------------------
  // Issue and return registers. The pointer only moves on a grant, so it is
  // naturally held while is_start is low or the FIFO is full.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      ce_rom_Occ_o   <= 1'b0;
      addr_rom_Occ_o <= '0;
      lane_valid_o   <= '0;
      lane_data_o    <= '0;
      err_o          <= 1'b0;
    end else begin
      ce_rom_Occ_o <= gnt_vld;
      if (gnt_vld) begin
        addr_rom_Occ_o <= lane_addr_i[int'(win)*ADDR_W +: ADDR_W];
        rr_ptr         <= (int'(win) == N_LANES-1) ? '0 : win + 1'b1;
      end
      lane_valid_o <= ret_vld ? (N_LANES'(1) << head_tag) : '0;
      if (ret_vld) begin
        lane_data_o <= data_Occ_i;
      end
      if (spur_vld) begin
        err_o <= 1'b1;
      end
    end
  end

  // The read just issued is already counted, but keep the strobe in the term so
  // busy never dips while a request is on the Occ bus.
  assign busy_o = (tag_count != '0) | ce_rom_Occ_o;

endmodule

// File: tb/tb_occ_port_arbiter.sv
// Randomized self-checking bench for occ_port_arbiter against a queue-based reference model.
// Inputs driven on the falling edge; grant sampled 1 time unit later, registered outputs on the next falling edge.
// The bench also plays the Occ memory (in-order returns) and the lanes (hold until granted).
module tb_occ_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MO = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            is_start;
  logic [N-1:0]    lane_ce_i;
  logic [N*AW-1:0] lane_addr_i;
  logic [N-1:0]    lane_gnt_o;
  logic [N-1:0]    lane_valid_o;
  logic [DW-1:0]   lane_data_o;
  logic            ce_rom_Occ_o;
  logic [AW-1:0]   addr_rom_Occ_o;
  logic [DW-1:0]   data_Occ_i;
  logic            data_Occ_valid_i;
  logic            busy_o;
  logic            err_o;

  always #5 clk = ~clk;

  occ_port_arbiter #(
    .N_LANES (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .MAX_OUT (MO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .is_start         (is_start),
    .lane_ce_i        (lane_ce_i),
    .lane_addr_i      (lane_addr_i),
    .lane_gnt_o       (lane_gnt_o),
    .lane_valid_o     (lane_valid_o),
    .lane_data_o      (lane_data_o),
    .ce_rom_Occ_o     (ce_rom_Occ_o),
    .addr_rom_Occ_o   (addr_rom_Occ_o),
    .data_Occ_i       (data_Occ_i),
    .data_Occ_valid_i (data_Occ_valid_i),
    .busy_o           (busy_o),
    .err_o            (err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- environment state ----
  bit            rst_drv;
  bit            st_drv;
  bit            lreq  [N];
  logic [AW-1:0] laddr [N];
  int            lane_mode;   // 0 random, 1 re-request after grant, 2 drop after grant
  bit            mem_hold;
  int            mem_credit;  // -1 unlimited, otherwise returns still allowed
  bit            spur_now;
  logic [AW-1:0] mem_pend[$];

  // ---- reference model ----
  typedef struct {
    int            lane;
    logic [AW-1:0] addr;
  } ent_t;

  ent_t          m_q[$];
  int            m_ptr;
  bit            m_err;
  bit            m_ce;
  logic [AW-1:0] m_addr;
  logic [N-1:0]  m_valid;
  logic [DW-1:0] m_data;
  bit            m_chk_data;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return {8'hC3, a, ~a, a ^ 8'h5A};
  endfunction

  task automatic step();
    bit           drove;
    int           win;
    logic [N-1:0] exp_gnt;
    ent_t         e;
    // drive inputs for this cycle
    rst_n    = rst_drv;
    is_start = st_drv;
    for (int i = 0; i < N; i++) begin
      lane_ce_i[i]            = lreq[i];
      lane_addr_i[i*AW +: AW] = laddr[i];
    end
    drove            = 1'b0;
    data_Occ_valid_i = 1'b0;
    data_Occ_i       = $urandom;
    if (!mem_hold && mem_pend.size() > 0 && mem_credit != 0 &&
        (mem_credit > 0 || $urandom_range(0, 3) != 0)) begin
      data_Occ_valid_i = 1'b1;
      data_Occ_i       = mem_data(mem_pend[0]);
      drove            = 1'b1;
      if (mem_credit > 0) mem_credit--;
    end else if (spur_now) begin
      data_Occ_valid_i = 1'b1;
    end
    #1;
    // expected grant: first requester scanning up from the pointer
    win = -1;
    if (rst_drv && st_drv && m_q.size() < MO) begin
      for (int k = 0; k < N; k++) begin
        int l;
        l = (m_ptr + k) % N;
        if (win < 0 && lreq[l]) win = l;
      end
    end
    exp_gnt = (win >= 0) ? (N'(1) << win) : '0;
    chk("gnt", 32'(lane_gnt_o), 32'(exp_gnt));
    // model advances across the edge
    if (!rst_drv) begin
      m_q.delete();
      m_ptr      = 0;
      m_err      = 1'b0;
      m_ce       = 1'b0;
      m_addr     = '0;
      m_valid    = '0;
      m_data     = '0;
      m_chk_data = 1'b1;
    end else begin
      m_valid    = '0;
      m_chk_data = 1'b0;
      if (data_Occ_valid_i) begin
        if (m_q.size() > 0) begin
          e          = m_q.pop_front();
          m_valid    = N'(1) << e.lane;
          m_data     = mem_data(e.addr);
          m_chk_data = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      m_ce = (win >= 0);
      if (win >= 0) begin
        m_addr = laddr[win];
        m_ptr  = (win + 1) % N;
        e.lane = win;
        e.addr = laddr[win];
        m_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("ce", 32'(ce_rom_Occ_o), 32'(m_ce));
    chk("addr", 32'(addr_rom_Occ_o), 32'(m_addr));
    chk("lane_valid", 32'(lane_valid_o), 32'(m_valid));
    if (m_chk_data) chk("lane_data", lane_data_o, m_data);
    chk("busy", 32'(busy_o), 32'((m_q.size() != 0) || m_ce));
    chk("err", 32'(err_o), 32'(m_err));
    // memory bookkeeping
    if (drove) void'(mem_pend.pop_front());
    if (ce_rom_Occ_o) mem_pend.push_back(addr_rom_Occ_o);
    // lanes: a granted lane drops or moves on; idle lanes may start
    for (int i = 0; i < N; i++) begin
      if (i == win) begin
        case (lane_mode)
          1: begin lreq[i] = 1'b1; laddr[i] = AW'($urandom); end
          2: lreq[i] = 1'b0;
          default: begin lreq[i] = 1'($urandom_range(0, 1)); laddr[i] = AW'($urandom); end
        endcase
      end else if (!lreq[i] && lane_mode == 0 && $urandom_range(0, 2) == 0) begin
        lreq[i]  = 1'b1;
        laddr[i] = AW'($urandom);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_drv = 1'b0;
    step();
    rst_drv = 1'b1;
  endtask

  task automatic lanes_idle();
    for (int i = 0; i < N; i++) lreq[i] = 1'b0;
  endtask

  initial begin
    rst_drv    = 1'b0;
    st_drv     = 1'b1;
    lane_mode  = 2;
    mem_hold   = 1'b0;
    mem_credit = -1;
    spur_now   = 1'b0;
    for (int i = 0; i < N; i++) begin
      lreq[i]  = 1'b0;
      laddr[i] = '0;
    end
    rst_n            = 1'b0;
    is_start         = 1'b0;
    lane_ce_i        = '0;
    lane_addr_i      = '0;
    data_Occ_i       = '0;
    data_Occ_valid_i = 1'b0;
    @(negedge clk);

    // reset state
    step();
    step();
    chk("reset_busy", 32'(busy_o), 0);
    chk("reset_err", 32'(err_o), 0);
    chk("reset_lane_valid", 32'(lane_valid_o), 0);
    rst_drv = 1'b1;

    // single lane request, memory holds then returns
    mem_hold = 1'b1;
    lreq[2]  = 1'b1;
    laddr[2] = 8'h35;
    step();
    chk("single_addr", 32'(addr_rom_Occ_o), 32'h35);
    run(2);
    mem_hold = 1'b0;
    run(6);

    // all lanes requesting continuously from pointer 0
    do_reset();
    lane_mode = 1;
    for (int i = 0; i < N; i++) begin
      lreq[i]  = 1'b1;
      laddr[i] = AW'($urandom);
    end
    run(12);
    lane_mode = 2;
    run(20);

    // full back-pressure: memory withholds, then exactly one return
    do_reset();
    mem_hold  = 1'b1;
    lane_mode = 1;
    for (int i = 0; i < N; i++) lreq[i] = 1'b1;
    run(7);
    chk("full_gnt", 32'(lane_gnt_o), 0);
    chk("full_busy", 32'(busy_o), 1);
    mem_hold   = 1'b0;
    mem_credit = 1;
    run(4);
    mem_credit = -1;
    lane_mode  = 2;
    run(24);

    // spurious return with nothing outstanding
    lanes_idle();
    do_reset();
    spur_now = 1'b1;
    step();
    spur_now = 1'b0;
    chk("spur_err", 32'(err_o), 1);
    chk("spur_lane_valid", 32'(lane_valid_o), 0);
    run(3);
    chk("spur_err_held", 32'(err_o), 1);

    // is_start drops with two reads outstanding
    do_reset();
    mem_hold = 1'b1;
    lreq[0]  = 1'b1;
    laddr[0] = 8'hA1;
    lreq[3]  = 1'b1;
    laddr[3] = 8'h3C;
    run(2);
    st_drv   = 1'b0;
    lreq[1]  = 1'b1;
    laddr[1] = 8'h77;
    run(3);
    mem_hold = 1'b0;
    run(12);
    chk("stop_busy", 32'(busy_o), 0);
    chk("stop_err", 32'(err_o), 0);
    st_drv = 1'b1;
    run(10);

    // reset with three reads outstanding, late returns afterwards
    do_reset();
    mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lreq[i]  = 1'b1;
      laddr[i] = AW'(8'h10 + i);
    end
    run(3);
    rst_drv = 1'b0;
    step();
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_ce", 32'(ce_rom_Occ_o), 0);
    rst_drv  = 1'b1;
    mem_hold = 1'b0;
    run(10);
    chk("late_err", 32'(err_o), 1);

    // long randomized run
    mem_pend.delete();
    do_reset();
    lane_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      st_drv   = ($urandom_range(0, 7) != 0);
      mem_hold = ($urandom_range(0, 4) == 0);
      step();
    end
    st_drv    = 1'b1;
    mem_hold  = 1'b0;
    lane_mode = 2;
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
